e203_itcm_sram_ctrl: RTL and testbench
======================================

# e203_itcm_sram_ctrl

Initiator-side controller for the ITCM SRAM macro port (cs/we/addr/wem/din/dout). It accepts single-beat read/write commands on a valid/ready command channel, drives the SRAM with its 1-cycle read latency, and returns one response per command through a 2-entry response buffer so response back-pressure never loses SRAM data. It also provides a post-reset zero-initialisation sweep and an idle light-sleep request. It sits between the ITCM arbitration logic and the ITCM RAM wrapper.

## Interface
- AW, 13, SRAM word-address width (depth 2^AW)
- DW, 64, data width
- MW, 8, byte-write-mask width (DW/8)
- INIT_EN, 1, 1 = zero all words after reset before accepting commands
- LS_IDLE, 8, consecutive idle cycles before ram_ls asserts (>=1)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid & ready
- cmd_read  in  1  1 = read, 0 = write
- cmd_addr  in  AW  word address
- cmd_wdata  in  DW  write data
- cmd_wmask  in  MW  byte enables for writes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid & ready
- rsp_rdata  out  DW  read data; 0 for write responses
- init_busy  out  1  zero-init sweep in progress
- ram_cs, ram_we  out  1 each  SRAM chip select, write enable (active-high)
- ram_addr  out  AW;  ram_wem  out  MW;  ram_din  out  DW
- ram_dout  in  DW  SRAM read data, valid the cycle after a read select
- ram_ls  out  1  light-sleep request to SRAM

## Operation
- States: INIT (only if INIT_EN), RUN. Reset enters INIT when INIT_EN=1, otherwise RUN.
- INIT: ram_cs=1, ram_we=1, ram_wem=all ones, ram_din=0, ram_addr=init counter from 0 up to 2^AW-1. The counter increments each cycle. After the cycle that writes address 2^AW-1, the block moves to RUN. cmd_ready=0 and init_busy=1 throughout.
- RUN: ram_cs = cmd_valid & cmd_ready; ram_we = ~cmd_read; ram_addr/ram_wem/ram_din pass through from cmd_* (combinational).
- In-flight flag p1: set for the cycle after an accepted command, carrying its read flag.
- Response FIFO, 2 entries: written at the end of each cycle where p1=1. The entry data is ram_dout for a read and 0 for a write. The head drives rsp_valid/rsp_rdata; an entry pops on rsp_valid & rsp_ready.
- Credit: outstanding = fifo_count + p1. cmd_ready = RUN & ~ram_ls & (outstanding < 2 | (rsp_valid & rsp_ready)). The combinational path rsp_ready -> cmd_ready is intended.
- Idle counter: counts consecutive RUN cycles with no cmd_valid, p1=0 and FIFO empty, saturating at LS_IDLE. ram_ls is registered and asserts when the count reaches LS_IDLE.
- Wake: cmd_valid while ram_ls=1 clears ram_ls and the counter at the next edge. The command is accepted no earlier than the following cycle.
- Responses are returned in command order. Every accepted command produces exactly one response.

## Timing
- While rst=1 and after reset:
  - cmd_ready=0, rsp_valid=0, rsp_rdata=0, ram_cs=0, ram_we=0, ram_addr=0, ram_wem=0, ram_din=0, ram_ls=0.
  - FIFO empty, p1=0, idle count 0.
  - init_busy=INIT_EN, asserting asynchronously with rst.
- First edge after rst falls: INIT begins, with the address-0 write in the first cycle after deassertion.
- INIT lasts exactly 2^AW cycles. init_busy falls, and cmd_ready can rise, in the cycle after the last init write.
- Read latency: command accepted in cycle N, rsp_valid=1 in N+2 when the FIFO was empty.
- Write responses have the same latency. Write data is in the SRAM at the end of cycle N.
- Sustained throughput is 1 command/cycle when rsp_ready is held high.
- With rsp_ready=0, at most 2 commands are accepted. cmd_ready stays 0 until a pop.
- Pop and push in the same cycle: count unchanged, order preserved.
- Read-after-write to the same address in consecutive cycles returns the new data (SRAM write-first not required: the read is issued a cycle later).
- rst asserted mid-operation: in-flight and buffered responses are discarded, and INIT reruns if INIT_EN=1.

## Test plan
- AW=4, INIT_EN=1: release rst -> init_busy=1 for 16 cycles, ram_we=1 with addr 0..15 and din=0. Then cmd_ready=1. A read of addr 5 returns rsp_rdata=0 at N+2.
- Write addr 3 = 64'h0123_4567_89AB_CDEF with mask 8'hFF, then write addr 3 data 64'hFFFF_FFFF_FFFF_FFFF with mask 8'h01, then read addr 3 -> rsp_rdata=64'h0123_4567_89AB_CDFF. Three responses arrive in order, the first two with rdata=0.
- rsp_ready=0 with continuous cmd_valid -> exactly 2 commands accepted and cmd_ready stays 0. Raise rsp_ready -> responses drain in order, and cmd_ready rises in the same cycle as the first pop.
- rsp_ready=1 and back-to-back reads of addresses 0..7 over 8 cycles -> 8 consecutive rsp_valid cycles starting 2 cycles after the first accept, with no bubbles.
- LS_IDLE=8: idle for 8 cycles -> ram_ls=1. Then cmd_valid -> ram_ls=0 on the next edge, and the command is accepted one cycle later with ram_cs=1.
- Assert rst while 2 responses are buffered -> rsp_valid=0 immediately. After release, INIT reruns and none of the old responses appear.

Source files
------------

// File: rtl/e203_itcm_sram_ctrl.sv
// ITCM SRAM port controller: single-beat command channel, 2-entry response buffer,
// post-reset zero sweep and idle light-sleep request.
module e203_itcm_sram_ctrl #(
    parameter int AW      = 13,
    parameter int DW      = 64,
    parameter int MW      = 8,
    parameter int INIT_EN = 1,
    parameter int LS_IDLE = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_read,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [MW-1:0] cmd_wmask,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          init_busy,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [MW-1:0] ram_wem,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          ram_ls
);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [0:0] ST_START = (INIT_EN != 0) ? ST_INIT : ST_RUN;
    localparam int CW = $clog2(LS_IDLE + 1);
    localparam logic [CW-1:0] LS_MAX = CW'(LS_IDLE);

    logic [0:0]    state_reg, state_next;
    logic [AW-1:0] init_cnt_reg;
    logic          p1_reg, p1_read_reg;
    logic [DW-1:0] fifo_data_reg [2];
    logic          wr_ptr_reg, rd_ptr_reg;
    logic [1:0]    count_reg;
    logic [CW-1:0] idle_cnt_reg, idle_cnt_next;
    logic          ls_reg, ls_next;

    logic          in_init, in_run, accept, push, pop, idle, wake;
    logic [1:0]    outstanding;

    // Outputs are held quiet while rst is high even though the state already reads INIT.
    assign in_init     = (state_reg == ST_INIT) & ~rst;
    assign in_run      = (state_reg == ST_RUN) & ~rst;
    assign init_busy   = (state_reg == ST_INIT);
    assign rsp_valid   = (count_reg != 2'd0);
    assign rsp_rdata   = rsp_valid ? fifo_data_reg[rd_ptr_reg] : '0;
    assign pop         = rsp_valid & rsp_ready;
    assign push        = p1_reg;
    assign outstanding = count_reg + {1'b0, p1_reg};
    assign cmd_ready   = in_run & ~ls_reg & ((outstanding < 2'd2) | pop);
    assign accept      = cmd_valid & cmd_ready;
    assign ram_ls      = ls_reg;

    always_comb begin
        ram_cs   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_wem  = '0;
        ram_din  = '0;
        if (in_init) begin
            ram_cs   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = init_cnt_reg;
            ram_wem  = '1;
        end else if (in_run) begin
            ram_cs   = accept;
            ram_we   = ~cmd_read;
            ram_addr = cmd_addr;
            ram_wem  = cmd_wmask;
            ram_din  = cmd_wdata;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (state_reg == ST_INIT && init_cnt_reg == '1)
            state_next = ST_RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_START;
            init_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_INIT)
                init_cnt_reg <= init_cnt_reg + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_reg      <= 1'b0;
            p1_read_reg <= 1'b0;
        end else begin
            p1_reg      <= accept;
            p1_read_reg <= cmd_read;
        end
    end

    // Each entry captures SRAM data in the cycle after its read select; writes respond with zero.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                fifo_data_reg[gi] <= '0;
            else if (push && (wr_ptr_reg == 1'(gi)))
                fifo_data_reg[gi] <= p1_read_reg ? ram_dout : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
            if (push && !pop)
                count_reg <= count_reg + 2'd1;
            else if (pop && !push)
                count_reg <= count_reg - 2'd1;
        end
    end

    assign idle = in_run & ~cmd_valid & ~p1_reg & (count_reg == 2'd0);
    assign wake = cmd_valid & ls_reg;

    always_comb begin
        idle_cnt_next = '0;
        if (!wake && idle)
            idle_cnt_next = (idle_cnt_reg == LS_MAX) ? idle_cnt_reg : idle_cnt_reg + CW'(1);
        ls_next = ~wake & idle & (idle_cnt_next == LS_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_reg <= '0;
            ls_reg       <= 1'b0;
        end else begin
            idle_cnt_reg <= idle_cnt_next;
            ls_reg       <= ls_next;
        end
    end

endmodule

// File: tb/tb_e203_itcm_sram_ctrl.sv
// Directed bench for e203_itcm_sram_ctrl (AW=4): init sweep, masked writes, back-pressure,
// streaming reads, light-sleep wake and mid-operation reset.
module tb_e203_itcm_sram_ctrl;
    localparam int AW = 4;
    localparam int DW = 64;
    localparam int MW = 8;
    localparam logic [63:0] VAL_A = 64'hCAFE_F00D_1234_5678;
    localparam logic [63:0] VAL_B = 64'h8765_4321_0BAD_BEEF;
    localparam logic [63:0] VAL_X = 64'h0123_4567_89AB_CDFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid, cmd_ready, cmd_read;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [MW-1:0] cmd_wmask;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          init_busy, ram_cs, ram_we, ram_ls;
    logic [AW-1:0] ram_addr;
    logic [MW-1:0] ram_wem;
    logic [DW-1:0] ram_din, ram_dout;

    logic [63:0] mem [16];
    logic [63:0] exp_q [$];
    logic [63:0] tput_exp [8];
    logic [63:0] exp_head;
    int checks = 0;
    int errors = 0;

    e203_itcm_sram_ctrl #(.AW(AW), .DW(DW), .MW(MW), .INIT_EN(1), .LS_IDLE(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_busy(init_busy), .ram_cs(ram_cs), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wem(ram_wem), .ram_din(ram_din),
        .ram_dout(ram_dout), .ram_ls(ram_ls)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: byte-masked write, registered read.
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < 8; b++)
                    if (ram_wem[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
            end else begin
                ram_dout <= mem[ram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    // Response scoreboard: every pop must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_extra", 64'(exp_q.size()), 64'd1);
            end else begin
                exp_head = exp_q.pop_front();
                $display("rsp rdata=%h", rsp_rdata);
                check("rsp_rdata", rsp_rdata, exp_head);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the command.
    task automatic send(input logic rd, input logic [3:0] a, input logic [63:0] wd,
                        input logic [7:0] wm, input logic [63:0] ex);
        int n = 0;
        cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_wdata = wd; cmd_wmask = wm;
        @(negedge clk);
        while (!cmd_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", 64'(cmd_ready), 64'd1);
        $display("cmd %s addr=%0d wdata=%h wmask=%h", rd ? "rd" : "wr", a, wd, wm);
        exp_q.push_back(ex);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wmask = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        tput_exp = '{64'd0, 64'd0, 64'd0, VAL_X, 64'd0, 64'd0, 64'd0, VAL_A};

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        check("rst_ram_cs", 64'(ram_cs), 64'd0);
        check("rst_ram_we", 64'(ram_we), 64'd0);
        check("rst_ram_addr", 64'(ram_addr), 64'd0);
        check("rst_ram_wem", 64'(ram_wem), 64'd0);
        check("rst_ram_ls", 64'(ram_ls), 64'd0);
        check("rst_init_busy", 64'(init_busy), 64'd1);

        // Init sweep: 16 cycles writing zero to 0..15
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("init_busy", 64'(init_busy), 64'd1);
            check("init_cs_we", 64'({ram_cs, ram_we}), 64'd3);
            check("init_addr", 64'(ram_addr), 64'(i));
            check("init_wem_din", {56'd0, ram_wem} | ram_din, 64'hFF);
            check("init_cmd_ready", 64'(cmd_ready), 64'd0);
            @(posedge clk);
            #1;
        end

        // First read (addr 5): accepted in N, response in N+2
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 4'd5;
        @(negedge clk);
        check("run_init_busy", 64'(init_busy), 64'd0);
        check("run_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rd_cs_we_addr", 64'({ram_cs, ram_we, ram_addr}), 64'({1'b1, 1'b0, 4'd5}));
        exp_q.push_back(64'd0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("lat_n1_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("lat_n2_valid", 64'(rsp_valid), 64'd1);
        @(posedge clk);
        #1;

        // Masked writes then read-after-write
        send(1'b0, 4'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'd0);
        send(1'b0, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01, 64'd0);
        send(1'b1, 4'd3, 64'd0, 8'h00, VAL_X);
        wait_drain();

        // Back-pressure: only two accepted until a pop
        send(1'b0, 4'd7, VAL_A, 8'hFF, 64'd0);
        send(1'b0, 4'd9, VAL_B, 8'hFF, 64'd0);
        wait_drain();
        rsp_ready = 1'b0;
        acc = 0;
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 4'd7;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (cmd_valid && cmd_ready) begin
                acc++;
                exp_q.push_back(acc == 1 ? VAL_A : VAL_B);
            end
            @(posedge clk);
            #1 cmd_addr = (acc == 0) ? 4'd7 : 4'd9;
        end
        check("bp_accepted", 64'(acc), 64'd2);
        @(negedge clk);
        check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
        check("bp_head", rsp_rdata, VAL_A);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_on_pop", 64'(cmd_ready), 64'd1);
        exp_q.push_back(VAL_B);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_drain();

        // Streaming reads 0..7 then idle into light sleep
        for (int c = 0; c < 19; c++) begin
            cmd_valid = (c < 8); cmd_read = 1'b1; cmd_addr = 4'(c);
            @(negedge clk);
            if (c < 8) begin
                check("tput_ready", 64'(cmd_ready), 64'd1);
                exp_q.push_back(tput_exp[c]);
            end
            check("tput_valid", 64'(rsp_valid), 64'(c >= 2 && c <= 9));
            if (c >= 10) check("ls_assert", 64'(ram_ls), 64'(c >= 18));
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 4'd3;
        @(negedge clk);
        check("wake_ls_held", 64'(ram_ls), 64'd1);
        check("wake_blocked", 64'({cmd_ready, ram_cs}), 64'd0);
        @(negedge clk);
        check("wake_ls_clear", 64'(ram_ls), 64'd0);
        check("wake_accept", 64'({cmd_ready, ram_cs}), 64'd3);
        exp_q.push_back(VAL_X);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_drain();

        // Reset with two buffered responses
        rsp_ready = 1'b0;
        send(1'b1, 4'd7, 64'd0, 8'h00, VAL_A);
        send(1'b1, 4'd9, 64'd0, 8'h00, VAL_B);
        @(posedge clk);
        #1;
        check("pre_rst_valid", 64'(rsp_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_busy", 64'(init_busy), 64'd1);
        check("mid_rst_ready", 64'(cmd_ready), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("reinit_addr", 64'({init_busy, ram_we, ram_addr}), 64'({2'b11, 4'(i)}));
            check("reinit_no_rsp", 64'(rsp_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("reinit_done", 64'({init_busy, rsp_valid}), 64'd0);
        @(posedge clk);
        #1;
        send(1'b1, 4'd7, 64'd0, 8'h00, 64'd0);
        wait_drain();
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
